// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - instruction phase sequencer with run/step/halt control and memory wait-state watchdog
// Optional: PHASE_SEQ_INSTR_CNT_EN adds the instr_count output.
module phase_sequencer #(
    parameter int NUM_PHASES = 8,
    parameter int PW         = 3,
    parameter int WAIT_MAX   = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run_req,
    input  logic          step_req,
    input  logic          err_clr,
    input  logic          halt,
    input  logic          rd,
    input  logic          wr,
    input  logic          mem_ready,
    output logic [PW-1:0] phase,
    output logic          running,
    output logic          halted,
    output logic          stall,
    output logic          instr_done,
`ifdef PHASE_SEQ_INSTR_CNT_EN
    output logic [15:0]   instr_count,
`endif
    output logic          timeout_err
);

    // WAIT_MAX=0 still needs a legal one-bit counter even though the watchdog is off
    localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [WW-1:0] WAIT_LAST  = WW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
    localparam logic [PW-1:0] PHASE_LAST = PW'(NUM_PHASES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        HALTED = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t         state, state_n;
    logic [PW-1:0]  phase_n;
    logic [WW-1:0]  wait_cnt, wait_n;
    logic           done_n;
    logic           step_prev;
    logic           step_rise;
    logic           active;
    logic           wrap;

    assign active    = (state == RUN) || (state == STEP);
    assign stall     = active && (rd || wr) && !mem_ready;
    assign wrap      = (phase == PHASE_LAST);
    assign step_rise = step_req && !step_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            wait_cnt   <= '0;
            instr_done <= 1'b0;
            step_prev  <= 1'b0;
        end else begin
            state      <= state_n;
            phase      <= phase_n;
            wait_cnt   <= wait_n;
            instr_done <= done_n;
            step_prev  <= step_req;
        end
    end

`ifdef PHASE_SEQ_INSTR_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count <= '0;
        end else if (done_n) begin
            instr_count <= instr_count + 16'd1;
        end
    end
`endif

    always_comb begin
        state_n = state;
        phase_n = phase;
        wait_n  = wait_cnt;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                phase_n = '0;
                wait_n  = '0;
                if (run_req) begin
                    state_n = RUN;
                end else if (step_rise) begin
                    state_n = STEP;
                end
            end
            RUN, STEP: begin
                if (stall) begin
                    if (WAIT_MAX > 0 && wait_cnt == WAIT_LAST) begin
                        state_n = ERROR;
                    end
                    if (wait_cnt != '1) begin
                        wait_n = wait_cnt + WW'(1);
                    end
                end else begin
                    wait_n = '0;
                    // a halt on the wrap cycle still wins and swallows the done pulse
                    if (halt) begin
                        state_n = HALTED;
                        phase_n = '0;
                    end else if (wrap) begin
                        phase_n = '0;
                        done_n  = 1'b1;
                        if (state == STEP) begin
                            state_n = IDLE;
                        end
                    end else begin
                        phase_n = phase + PW'(1);
                    end
                end
            end
            HALTED: begin
                phase_n = '0;
                if (run_req) begin
                    state_n = RUN;
                end else if (step_rise) begin
                    state_n = STEP;
                end
            end
            ERROR: begin
                if (err_clr) begin
                    state_n = IDLE;
                    phase_n = '0;
                    wait_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
                wait_n  = '0;
            end
        endcase
    end

    assign running     = active;
    assign halted      = (state == HALTED);
    assign timeout_err = (state == ERROR);

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed self-checking bench for phase_sequencer
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst, run_req, step_req, err_clr, halt, rd, wr, mem_ready;
    logic [2:0] phase;
    logic       running, halted, stall, instr_done, timeout_err;
`ifdef PHASE_SEQ_INSTR_CNT_EN
    logic [15:0] instr_count;
`endif

    int tests  = 0;
    int failed = 0;

    phase_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run_req    (run_req),
        .step_req   (step_req),
        .err_clr    (err_clr),
        .halt       (halt),
        .rd         (rd),
        .wr         (wr),
        .mem_ready  (mem_ready),
        .phase      (phase),
        .running    (running),
        .halted     (halted),
        .stall      (stall),
        .instr_done (instr_done),
`ifdef PHASE_SEQ_INSTR_CNT_EN
        .instr_count(instr_count),
`endif
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ph, input int run, input int hlt,
                           input int stl, input int dn, input int to);
        chk({tag, ".phase"},   32'(phase),       32'(ph));
        chk({tag, ".running"}, 32'(running),     32'(run));
        chk({tag, ".halted"},  32'(halted),      32'(hlt));
        chk({tag, ".stall"},   32'(stall),       32'(stl));
        chk({tag, ".done"},    32'(instr_done),  32'(dn));
        chk({tag, ".timeout"}, 32'(timeout_err), 32'(to));
    endtask

    initial begin
        rst = 1'b1; run_req = 1'b0; step_req = 1'b0; err_clr = 1'b0;
        halt = 1'b0; rd = 1'b0; wr = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
`ifdef PHASE_SEQ_INSTR_CNT_EN
        chk("reset.count", 32'(instr_count), 32'd0);
`endif

        // free run: entry edge keeps phase 0, then 1..7, wrap to 0 with a done pulse
        rst = 1'b0; run_req = 1'b1;
        tick();
        chk_all("run_entry", 0, 1, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("run.phase", 32'(phase), 32'(i));
            chk("run.done", 32'(instr_done), 32'd0);
        end
        tick();
        chk_all("run_wrap", 0, 1, 0, 0, 1, 0);
        tick();
        chk_all("run_after_wrap", 1, 1, 0, 0, 0, 0);

        // memory stall at phase 4 for 3 cycles
        tick(); tick(); tick();
        chk("pre_stall.phase", 32'(phase), 32'd4);
        rd = 1'b1; mem_ready = 1'b0;
        #1;
        chk("stall_comb", 32'(stall), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("stall_hold", 4, 1, 0, 1, 0, 0);
        end
        mem_ready = 1'b1;
        #1;
        chk("stall_release_comb", 32'(stall), 32'd0);
        tick();
        chk_all("stall_done", 5, 1, 0, 0, 0, 0);
        rd = 1'b0; mem_ready = 1'b0;

        // 5 -> 6,7,0,1,2,3 then halt at phase 3
        for (int i = 0; i < 6; i++) tick();
        chk("pre_halt.phase", 32'(phase), 32'd3);
        halt = 1'b1; run_req = 1'b0;
        tick();
        chk_all("halt", 0, 0, 1, 0, 0, 0);
        halt = 1'b0;
        tick();
        chk_all("halted_hold", 0, 0, 1, 0, 0, 0);
`ifdef PHASE_SEQ_INSTR_CNT_EN
        chk("halted.count", 32'(instr_count), 32'd2);
`endif
        run_req = 1'b1;
        tick();
        chk_all("resume", 0, 1, 0, 0, 0, 0);
        tick();
        chk_all("resume_adv", 1, 1, 0, 0, 0, 0);

        // 14 stalls then mem_ready on the 15th cycle: no error
        rd = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk_all("stall14", 1, 1, 0, 1, 0, 0);
        mem_ready = 1'b1;
        tick();
        chk_all("ready_at_15", 2, 1, 0, 0, 0, 0);

        // 15 consecutive stalls: error on the 15th
        mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk_all("stall14b", 2, 1, 0, 1, 0, 0);
        tick();
        chk_all("timeout", 2, 0, 0, 0, 0, 1);
        run_req = 1'b0; rd = 1'b0;
        tick();
        chk_all("error_sticky", 2, 0, 0, 0, 0, 1);
        err_clr = 1'b1;
        tick();
        chk_all("err_clr", 0, 0, 0, 0, 0, 0);
        err_clr = 1'b0;
`ifdef PHASE_SEQ_INSTR_CNT_EN
        chk("err_clr.count", 32'(instr_count), 32'd2);
`endif

        // single step from IDLE, held step_req gives no repeat
        step_req = 1'b1;
        tick();
        chk_all("step_entry", 0, 1, 0, 0, 0, 0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("step.phase", 32'(phase), 32'(i));
        end
        tick();
        chk_all("step_wrap", 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("step_held", 0, 0, 0, 0, 0, 0);
        end
`ifdef PHASE_SEQ_INSTR_CNT_EN
        chk("step.count", 32'(instr_count), 32'd3);
`endif
        step_req = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        chk_all("step_again", 0, 1, 0, 0, 0, 0);
        step_req = 1'b0;

        // async reset in the middle of a stall at phase 5
        for (int i = 0; i < 5; i++) tick();
        rd = 1'b1; mem_ready = 1'b0;
        tick();
        chk_all("pre_rst_stall", 5, 1, 0, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
`ifdef PHASE_SEQ_INSTR_CNT_EN
        chk("async_rst.count", 32'(instr_count), 32'd0);
`endif
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
